axis_frame_sink: RTL and testbench
==================================

AXIS_FRAME_SINK -- requirements
Module: axis_frame_sink

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 64: s_axis_tdata width in bits.
REQ-002 The block SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8: tkeep width, one bit per byte.
REQ-003 The block SHALL have parameter ID_WIDTH, default 8: tid and descriptor id width.
REQ-004 The block SHALL have parameter DEST_WIDTH, default 8: tdest and descriptor dest width.
REQ-005 The block SHALL have parameter USER_WIDTH, default 1: tuser width; bit 0 is the bad-frame flag.
REQ-006 The block SHALL have parameter LEN_WIDTH, default 16: byte-length counter width.
REQ-007 The block SHALL have parameter MAX_LEN, default 1518: oversize threshold in bytes, used only when the macro is defined.
REQ-008 The block SHALL have one clock and synchronous active-low reset, with ports clk (in, 1, rising-edge clock) and rst (in, 1, synchronous active-low reset).
REQ-009 The block SHALL have the following AXI stream input ports: s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tid, s_axis_tdest and s_axis_tuser (in, widths per parameters); s_axis_tready (out, 1).
REQ-010 The block SHALL have descriptor outputs m_desc_len (out, LEN_WIDTH, frame byte count), m_desc_id (out, ID_WIDTH), m_desc_dest (out, DEST_WIDTH), m_desc_error (out, 1, tuser[0] seen on any beat), m_desc_oversize (out, 1) and m_desc_valid (out, 1); and descriptor input m_desc_ready (in, 1).
REQ-011 The block SHALL have status outputs busy (out, 1, mid-frame) and frame_count (out, 32, descriptors issued, wraps modulo 2^32).

Function
REQ-012 A beat SHALL be accepted when s_axis_tvalid and s_axis_tready are both high on a clk edge.
REQ-013 s_axis_tready SHALL equal (!m_desc_valid || m_desc_ready) while rst is high, and SHALL be 0 while rst is low.
REQ-014 The state machine SHALL have states IDLE (awaiting first beat) and FRAME (mid-frame); an accepted non-last beat moves the block to FRAME, and an accepted last beat returns it to IDLE.
REQ-015 On the first accepted beat of a frame (state IDLE), s_axis_tid and s_axis_tdest SHALL be captured; later beats' tid/tdest SHALL be ignored.
REQ-016 The byte count per beat SHALL be popcount(s_axis_tkeep), and the frame length SHALL be the sum over beats, saturating at 2^LEN_WIDTH-1 and never wrapping.
REQ-017 The error flag SHALL be the OR of s_axis_tuser[0] over all beats of the frame.
REQ-018 On an accepted tlast beat, the descriptor register SHALL load {length including that beat, id, dest, error, oversize}, m_desc_valid SHALL be 1 on the next cycle, and the accumulators SHALL clear; latency from tlast acceptance to descriptor valid is 1 cycle.
REQ-019 A single-beat frame (tlast on the first beat) SHALL use that beat's tid/tdest and length popcount(tkeep).
REQ-020 A beat with tkeep all-zero SHALL add 0 bytes but SHALL still count as a beat, including for tlast.
REQ-021 m_desc_valid SHALL clear after a cycle with m_desc_ready high unless a new tlast is accepted in that same cycle, in which case the new descriptor SHALL load and valid SHALL stay 1.
REQ-022 Descriptor outputs SHALL hold stable while m_desc_valid=1 and m_desc_ready=0.
REQ-023 frame_count SHALL increment by 1 on each descriptor load.
REQ-024 busy SHALL be 1 exactly when state is FRAME.

Reset
REQ-025 While rst=0 at a clk edge, the block SHALL go to state IDLE, with m_desc_valid=0, m_desc_len/id/dest/error/oversize=0, frame_count=0, busy=0, accumulators=0 and s_axis_tready=0.
REQ-026 Reset mid-frame SHALL discard the partial frame with no descriptor; the first beat after reset starts a new frame.

Configuration
REQ-027 With macro AXIS_FRAME_SINK_OVERSIZE_EN defined, m_desc_oversize SHALL be 1 when the unsaturated frame length exceeds MAX_LEN.
REQ-028 Without AXIS_FRAME_SINK_OVERSIZE_EN, m_desc_oversize SHALL be tied to 0, no comparator SHALL be built, and MAX_LEN SHALL be unused.

Structure
REQ-029 A shared package axis_frame_sink_pkg SHALL hold the state enum (IDLE, FRAME) and the descriptor struct type; parameters stay on the module.
REQ-030 The design SHALL contain one sub-module, axis_keep_popcount, a combinational KEEP_WIDTH-to-count function; all other logic stays in the top module.

Verification
REQ-031 The bench SHALL apply 3 beats with tkeep=FF, FF, 0F, tlast on beat 3, tid=5 and tdest=2 on beat 1, and m_desc_ready=1, and SHALL check len=20, id=5, dest=2, error=0, valid 1 cycle after beat 3 and frame_count=1.
REQ-032 The bench SHALL apply a single beat with tkeep=01, tlast=1 and tuser=1, and SHALL check len=1 and error=1.
REQ-033 The bench SHALL hold m_desc_ready=0 while two back-to-back frames are sent, check s_axis_tready=0 after the first descriptor, hold the second frame, and check after m_desc_ready=1 that both descriptors appear in order with no gap.
REQ-034 The bench SHALL apply rst=0 mid-frame after 2 beats, then a fresh 1-beat frame with tkeep=FF, and SHALL check that only len=8 is reported and frame_count=1.
REQ-035 With AXIS_FRAME_SINK_OVERSIZE_EN and MAX_LEN=16, the bench SHALL check that a 3-beat frame of 17 bytes gives oversize=1 and a 16-byte frame gives oversize=0; without the macro, the bench SHALL check that oversize is always 0.
REQ-036 The bench SHALL set LEN_WIDTH=4 and apply 3 beats with tkeep=FF, and SHALL check len=15 (saturated).

Source files
------------

// File: rtl/axis_frame_sink_pkg.sv
// -----------------------------------------------------------------------------
// axis_frame_sink_pkg
// Shared types for the AXI-stream frame sink.
//   state_e      : frame tracking FSM states (IDLE awaiting first beat, FRAME
//                  mid-frame).
//   desc_flags_t : width-independent part of the frame descriptor. The
//                  length, id and dest fields are sized by module parameters,
//                  so they are kept as separate registers in the top module.
// Build option: none in this file. AXIS_FRAME_SINK_OVERSIZE_EN is used by the
// top module only.
// -----------------------------------------------------------------------------
package axis_frame_sink_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } state_e;

  typedef struct packed {
    logic error;     // tuser[0] was seen on at least one beat
    logic oversize;  // unsaturated frame length exceeded MAX_LEN
  } desc_flags_t;

endpackage : axis_frame_sink_pkg

// File: rtl/axis_keep_popcount.sv
// -----------------------------------------------------------------------------
// axis_keep_popcount
// Purely combinational count of set bits in a tkeep vector, i.e. the number
// of valid bytes carried by one AXI-stream beat.
// Ports:
//   keep_i  (in,  KEEP_WIDTH) : tkeep of the current beat
//   count_o (out, CNT_W)      : number of ones in keep_i
// Build option: none.
// -----------------------------------------------------------------------------
module axis_keep_popcount
  import axis_frame_sink_pkg::*;
#(
  parameter int KEEP_WIDTH = 8,
  parameter int CNT_W      = $clog2(KEEP_WIDTH + 1)
) (
  input  logic [KEEP_WIDTH-1:0] keep_i,
  output logic [CNT_W-1:0]      count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      count_o = count_o + CNT_W'(keep_i[i]);
    end
  end

endmodule : axis_keep_popcount

// File: rtl/axis_frame_sink.sv
// -----------------------------------------------------------------------------
// axis_frame_sink
// Consumes an AXI-stream and emits one descriptor per frame: byte length
// (saturating), tid/tdest of the first beat, an error flag (OR of tuser[0])
// and an oversize flag. A single descriptor register is used; the stream is
// back-pressured while a descriptor is waiting and m_desc_ready is low.
// Ports:
//   clk, rst            : clock, synchronous active-low reset
//   s_axis_*            : AXI-stream slave (tdata is not stored)
//   m_desc_*            : descriptor valid/ready output
//   busy                : 1 while mid-frame
//   frame_count         : number of descriptors issued, wraps at 2^32
// Build option: define AXIS_FRAME_SINK_OVERSIZE_EN to build the MAX_LEN
// comparator; otherwise m_desc_oversize is tied to 0.
// -----------------------------------------------------------------------------
module axis_frame_sink
  import axis_frame_sink_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 1,
  parameter int LEN_WIDTH  = 16,
  parameter int MAX_LEN    = 1518
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic [ID_WIDTH-1:0]   s_axis_tid,
  input  logic [DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic                  s_axis_tready,
  output logic [LEN_WIDTH-1:0]  m_desc_len,
  output logic [ID_WIDTH-1:0]   m_desc_id,
  output logic [DEST_WIDTH-1:0] m_desc_dest,
  output logic                  m_desc_error,
  output logic                  m_desc_oversize,
  output logic                  m_desc_valid,
  input  logic                  m_desc_ready,
  output logic                  busy,
  output logic [31:0]           frame_count
);

  localparam int CNT_W = $clog2(KEEP_WIDTH + 1);
  localparam int SUM_W = LEN_WIDTH + 1;

  // Frame accumulators
  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [DEST_WIDTH-1:0] dest_q, dest_d;
  logic                  err_q, err_d;

  // Descriptor register
  logic [LEN_WIDTH-1:0]  desc_len_q, desc_len_d;
  logic [ID_WIDTH-1:0]   desc_id_q, desc_id_d;
  logic [DEST_WIDTH-1:0] desc_dest_q, desc_dest_d;
  desc_flags_t           desc_flags_q, desc_flags_d;
  logic                  desc_valid_q, desc_valid_d;
  logic [31:0]           frame_count_q, frame_count_d;

  logic [CNT_W-1:0]      beat_bytes;
  logic                  accept;
  logic [SUM_W-1:0]      len_sum;
  logic [LEN_WIDTH-1:0]  len_sat;
  logic [ID_WIDTH-1:0]   frame_id;
  logic [DEST_WIDTH-1:0] frame_dest;
  logic                  frame_err;
  logic                  frame_oversize;

  // tdata is never stored and only tuser[0] carries meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{s_axis_tdata, s_axis_tuser};

  axis_keep_popcount #(
    .KEEP_WIDTH (KEEP_WIDTH),
    .CNT_W      (CNT_W)
  ) u_keep_popcount (
    .keep_i  (s_axis_tkeep),
    .count_o (beat_bytes)
  );

  // The descriptor slot is free when empty or being drained this cycle.
  assign s_axis_tready = rst & (~desc_valid_q | m_desc_ready);
  assign accept        = s_axis_tvalid & s_axis_tready;

  // One extra bit catches the carry so the length sticks at all-ones.
  assign len_sum = {1'b0, len_q} + SUM_W'(beat_bytes);
  assign len_sat = len_sum[LEN_WIDTH] ? {LEN_WIDTH{1'b1}} : len_sum[LEN_WIDTH-1:0];

  // First beat of a frame supplies tid/tdest; later beats reuse the capture.
  assign frame_id   = (state_q == IDLE) ? s_axis_tid : id_q;
  assign frame_dest = (state_q == IDLE) ? s_axis_tdest : dest_q;
  assign frame_err  = err_q | s_axis_tuser[0];

`ifdef AXIS_FRAME_SINK_OVERSIZE_EN
  // Separate counter that saturates just above MAX_LEN, so the comparison
  // stays exact even after the reported length has saturated.
  localparam int                OV_W     = $clog2(MAX_LEN + KEEP_WIDTH + 2);
  localparam logic [OV_W-1:0]   OV_LIMIT = OV_W'(MAX_LEN);
  localparam logic [OV_W-1:0]   OV_CAP   = OV_W'(MAX_LEN + 1);

  logic [OV_W-1:0] ov_q, ov_d, ov_sum;

  assign ov_sum         = ov_q + OV_W'(beat_bytes);
  assign frame_oversize = (ov_sum > OV_LIMIT);

  always_comb begin
    ov_d = ov_q;
    if (accept) begin
      if (s_axis_tlast) begin
        ov_d = '0;
      end else begin
        ov_d = frame_oversize ? OV_CAP : ov_sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ov_q <= '0;
    end else begin
      ov_q <= ov_d;
    end
  end
`else
  logic unused_max_len;
  assign unused_max_len = (MAX_LEN > 0);
  assign frame_oversize = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    id_d          = id_q;
    dest_d        = dest_q;
    err_d         = err_q;
    desc_len_d    = desc_len_q;
    desc_id_d     = desc_id_q;
    desc_dest_d   = desc_dest_q;
    desc_flags_d  = desc_flags_q;
    desc_valid_d  = desc_valid_q & ~m_desc_ready;
    frame_count_d = frame_count_q;

    case (state_q)
      IDLE:    if (accept && !s_axis_tlast) state_d = FRAME;
      FRAME:   if (accept && s_axis_tlast)  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      if (s_axis_tlast) begin
        // A load on the same cycle as a drain keeps valid asserted.
        desc_len_d            = len_sat;
        desc_id_d             = frame_id;
        desc_dest_d           = frame_dest;
        desc_flags_d.error    = frame_err;
        desc_flags_d.oversize = frame_oversize;
        desc_valid_d          = 1'b1;
        frame_count_d         = frame_count_q + 32'd1;
        len_d                 = '0;
        id_d                  = '0;
        dest_d                = '0;
        err_d                 = 1'b0;
      end else begin
        len_d  = len_sat;
        id_d   = frame_id;
        dest_d = frame_dest;
        err_d  = frame_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      len_q         <= '0;
      id_q          <= '0;
      dest_q        <= '0;
      err_q         <= 1'b0;
      desc_len_q    <= '0;
      desc_id_q     <= '0;
      desc_dest_q   <= '0;
      desc_flags_q  <= '0;
      desc_valid_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      id_q          <= id_d;
      dest_q        <= dest_d;
      err_q         <= err_d;
      desc_len_q    <= desc_len_d;
      desc_id_q     <= desc_id_d;
      desc_dest_q   <= desc_dest_d;
      desc_flags_q  <= desc_flags_d;
      desc_valid_q  <= desc_valid_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign m_desc_len      = desc_len_q;
  assign m_desc_id       = desc_id_q;
  assign m_desc_dest     = desc_dest_q;
  assign m_desc_error    = desc_flags_q.error;
  assign m_desc_oversize = desc_flags_q.oversize;
  assign m_desc_valid    = desc_valid_q;
  assign busy            = (state_q == FRAME);
  assign frame_count     = frame_count_q;

endmodule : axis_frame_sink

// File: tb/tb_axis_frame_sink.sv
// -----------------------------------------------------------------------------
// tb_axis_frame_sink
// Scoreboard bench: the driver pushes the expected descriptor into a queue
// when a tlast beat is accepted; a monitor pops and compares on every
// descriptor handshake. Two instances share the stream: one with a 16-bit
// length and MAX_LEN=16, one with a 4-bit length to exercise saturation.
// -----------------------------------------------------------------------------
module tb_axis_frame_sink;

  localparam int MAXL     = 16;
  localparam int MAXL_S   = 1518;
  localparam int LEN_MAX  = 65535;
  localparam int LEN_MAX_S = 15;
`ifdef AXIS_FRAME_SINK_OVERSIZE_EN
  localparam bit OVS_EN = 1'b1;
`else
  localparam bit OVS_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tvalid;
  logic        tlast;
  logic [7:0]  tid;
  logic [7:0]  tdest;
  logic [0:0]  tuser;
  logic        m_desc_ready;

  logic        tready, valid, err, ovs, busy;
  logic [15:0] len;
  logic [7:0]  id, dest;
  logic [31:0] fc;

  logic        s_tready, s_valid, s_err, s_ovs, s_busy;
  logic [3:0]  s_len;
  logic [7:0]  s_id, s_dest;
  logic [31:0] s_fc;

  axis_frame_sink #(
    .DATA_WIDTH(64), .KEEP_WIDTH(8), .ID_WIDTH(8), .DEST_WIDTH(8),
    .USER_WIDTH(1), .LEN_WIDTH(16), .MAX_LEN(MAXL)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tvalid(tvalid),
    .s_axis_tlast(tlast), .s_axis_tid(tid), .s_axis_tdest(tdest),
    .s_axis_tuser(tuser), .s_axis_tready(tready),
    .m_desc_len(len), .m_desc_id(id), .m_desc_dest(dest),
    .m_desc_error(err), .m_desc_oversize(ovs), .m_desc_valid(valid),
    .m_desc_ready(m_desc_ready), .busy(busy), .frame_count(fc)
  );

  axis_frame_sink #(
    .DATA_WIDTH(64), .KEEP_WIDTH(8), .ID_WIDTH(8), .DEST_WIDTH(8),
    .USER_WIDTH(1), .LEN_WIDTH(4), .MAX_LEN(MAXL_S)
  ) dut_small (
    .clk(clk), .rst(rst),
    .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tvalid(tvalid),
    .s_axis_tlast(tlast), .s_axis_tid(tid), .s_axis_tdest(tdest),
    .s_axis_tuser(tuser), .s_axis_tready(s_tready),
    .m_desc_len(s_len), .m_desc_id(s_id), .m_desc_dest(s_dest),
    .m_desc_error(s_err), .m_desc_oversize(s_ovs), .m_desc_valid(s_valid),
    .m_desc_ready(m_desc_ready), .busy(s_busy), .frame_count(s_fc)
  );

  typedef struct {
    int len;
    int len_s;
    int id;
    int dest;
    bit err;
    bit ovs;
    bit ovs_s;
  } exp_t;

  exp_t exp_q[$];

  // Reference model of the frame in progress
  int fr_bytes;
  int fr_id;
  int fr_dest;
  bit fr_err;
  bit fr_first;
  int exp_fc;

  int n_checks;
  int n_errors;
  int cyc;
  int pop_cyc;
  int prev_pop_cyc;
  int n_pops;
  int ready_mode = 1;  // 0: hold low, 1: hold high, 2: random

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Frame-level model: bytes add up, first beat names the frame.
  task automatic model_accept(input logic [7:0] keep, input bit last,
                              input int bid, input int bdest, input bit user);
    exp_t e;
    if (fr_first) begin
      fr_id    = bid;
      fr_dest  = bdest;
      fr_bytes = 0;
      fr_err   = 1'b0;
    end
    fr_bytes += $countones(keep);
    fr_err   |= user;
    fr_first  = 1'b0;
    if (last) begin
      e.len   = min_int(fr_bytes, LEN_MAX);
      e.len_s = min_int(fr_bytes, LEN_MAX_S);
      e.id    = fr_id;
      e.dest  = fr_dest;
      e.err   = fr_err;
      e.ovs   = OVS_EN && (fr_bytes > MAXL);
      e.ovs_s = OVS_EN && (fr_bytes > MAXL_S);
      exp_q.push_back(e);
      exp_fc++;
      fr_first = 1'b1;
      $display("beat  keep=%02h last=1 -> expect len=%0d id=%0d dest=%0d err=%0d ovs=%0d",
               keep, e.len, e.id, e.dest, e.err, e.ovs);
    end
  endtask

  // Called right after a posedge; returns right after the accepting posedge.
  task automatic beat(input logic [7:0] keep, input bit last,
                      input int bid, input int bdest, input bit user);
    int waited;
    #1;
    tkeep  = keep;
    tlast  = last;
    tid    = 8'(bid);
    tdest  = 8'(bdest);
    tuser  = user;
    tdata  = {$urandom, $urandom};
    tvalid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!tready) begin
      waited++;
      if (waited > 200) begin
        n_checks++;
        n_errors++;
        $display("FAIL beat_timeout: tready stayed 0 for %0d cycles", waited);
        tvalid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    model_accept(keep, last, bid, bdest, user);
  endtask

  task automatic gap(input int n);
    #1;
    tvalid = 1'b0;
    tlast  = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  // Sample between an active edge and the next beat's input update.
  task automatic peek();
    #2;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 300) begin
      @(posedge clk);
      waited++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && valid && m_desc_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL desc_unexpected: got len=%0d with no frame pending", len);
        end else begin
          e = exp_q.pop_front();
          $display("desc  len=%0d id=%0d dest=%0d err=%0d ovs=%0d small_len=%0d",
                   len, id, dest, err, ovs, s_len);
          check("desc_len", len, e.len);
          check("desc_id", id, e.id);
          check("desc_dest", dest, e.dest);
          check("desc_error", err, e.err);
          check("desc_oversize", ovs, e.ovs);
          check("small_valid", s_valid, 1);
          check("small_len", s_len, e.len_s);
          check("small_id", s_id, e.id);
          check("small_oversize", s_ovs, e.ovs_s);
          prev_pop_cyc = pop_cyc;
          pop_cyc      = cyc;
          n_pops++;
        end
      end
    end
  end

  // m_desc_ready driver
  initial begin
    m_desc_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_desc_ready = 1'b0;
        1:       m_desc_ready = 1'b1;
        default: m_desc_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int pops0;
    int nb;
    logic [7:0] k;
    rst      = 1'b0;
    tvalid   = 1'b0;
    tlast    = 1'b0;
    tkeep    = '0;
    tid      = '0;
    tdest    = '0;
    tuser    = '0;
    tdata    = '0;
    fr_first = 1'b1;
    exp_fc   = 0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tready", tready, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_count", fc, 0);
    check("rst_len", len, 0);
    check("rst_error", err, 0);
    check("rst_oversize", ovs, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("tready_after_rst", tready, 1);
    @(posedge clk);

    // Three beats FF,FF,0F; later beats carry different tid/tdest
    beat(8'hFF, 0, 5, 2, 0);
    peek();
    check("busy_mid_frame", busy, 1);
    beat(8'hFF, 0, 9, 9, 0);
    peek();
    check("valid_before_last", valid, 0);
    beat(8'h0F, 1, 11, 11, 0);
    peek();
    check("valid_1cyc_after_last", valid, 1);
    check("frame_count_1", fc, exp_fc);
    check("busy_after_last", busy, 0);
    gap(3);

    // Single beat, one byte, bad-frame flag
    beat(8'h01, 1, 3, 4, 1);
    gap(2);
    // tlast on an empty-keep beat
    beat(8'hFF, 0, 12, 13, 0);
    beat(8'h00, 1, 0, 0, 0);
    gap(2);
    drain();

    // Back-pressure: two frames with the descriptor slot held
    ready_mode = 0;
    repeat (2) @(posedge clk);
    beat(8'hFF, 0, 7, 1, 0);
    beat(8'h0F, 1, 7, 1, 0);
    peek();
    check("bp_tready_low", tready, 0);
    check("bp_valid", valid, 1);
    fork
      beat(8'h03, 1, 9, 3, 0);
      begin
        repeat (3) begin
          @(negedge clk);
          check("bp_hold_len", len, 12);
          check("bp_hold_tready", tready, 0);
        end
        ready_mode = 1;
      end
    join
    gap(3);
    check("bp_no_gap", pop_cyc - prev_pop_cyc, 1);
    drain();

    // Reset after two beats discards the partial frame
    beat(8'hFF, 0, 1, 1, 0);
    beat(8'hFF, 0, 1, 1, 0);
    #1;
    rst    = 1'b0;
    tvalid = 1'b0;
    repeat (2) @(posedge clk);
    fr_first = 1'b1;
    exp_fc   = 0;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_tready", tready, 0);
    check("midrst_frame_count", fc, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    pops0 = n_pops;
    beat(8'hFF, 1, 6, 6, 0);
    gap(3);
    check("midrst_one_desc", n_pops - pops0, 1);
    check("midrst_frame_count_1", fc, 1);

    // Oversize boundary (17 and 16 bytes) and saturation (24 bytes)
    beat(8'hFF, 0, 2, 2, 0);
    beat(8'hFF, 0, 2, 2, 0);
    beat(8'h01, 1, 2, 2, 0);
    gap(1);
    beat(8'hFF, 0, 3, 3, 0);
    beat(8'h0F, 0, 3, 3, 0);
    beat(8'h0F, 1, 3, 3, 0);
    gap(1);
    beat(8'hFF, 0, 4, 4, 0);
    beat(8'hFF, 0, 4, 4, 0);
    beat(8'hFF, 1, 4, 4, 0);
    gap(2);
    drain();

    // Randomized frames with random descriptor back-pressure
    ready_mode = 2;
    for (int f = 0; f < 60; f++) begin
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        case ($urandom_range(0, 7))
          0:       k = 8'h00;
          1:       k = 8'hFF;
          default: k = 8'($urandom);
        endcase
        beat(k, (b == nb - 1), $urandom_range(0, 255), $urandom_range(0, 255),
             ($urandom_range(0, 9) == 0));
      end
      gap($urandom_range(0, 2));
    end
    ready_mode = 1;
    gap(2);
    drain();
    check("final_frame_count", fc, exp_fc);
    check("final_small_frame_count", s_fc, exp_fc);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_axis_frame_sink
